// File: rtl/tt_mod6_pkg.sv
// Shared types and constants for the modulo-6 sequence checker.
// Holds the lock-FSM state encodings, the modulus and the error-count ceiling.
package tt_mod6_pkg;

   typedef enum logic [1:0] {
      ST_HUNT   = 2'b00,
      ST_VERIFY = 2'b01,
      ST_LOCKED = 2'b10,
      ST_SLIP   = 2'b11
   } state_t;

   localparam int         MOD     = 6;
   localparam logic [7:0] ERR_MAX = 8'd255;

   // Width of the good/bad run counters; both limits are at most 7.
   localparam int         CNT_W   = 3;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == ERR_MAX) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/mod6_next.sv
// Successor of a modulo-6 count value, plus detection of the unused codes 6 and 7.
// Illegal inputs report next_value = 0 so downstream logic never sees 6 or 7.
module mod6_next
   import tt_mod6_pkg::*;
(
   input  logic [2:0] value,
   output logic [2:0] next_value,
   output logic       illegal
);

   localparam logic [2:0] LAST = 3'(MOD - 1);

   always_comb begin
      illegal = (value > LAST);
      if (illegal || (value == LAST)) begin
         next_value = 3'd0;
      end else begin
         next_value = value + 3'd1;
      end
   end

endmodule

// File: rtl/tt_um_mod6_checker.sv
// Lock-and-track checker for an observed modulo-6 counter stream.
// Acquires lock after LOCK_COUNT in-sequence samples, flywheels through errors, drops after LOSS_COUNT.
module tt_um_mod6_checker
   import tt_mod6_pkg::*;
#(
   parameter int LOCK_COUNT = 3,
   parameter int LOSS_COUNT = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam logic [CNT_W-1:0] LOCK_N = CNT_W'(LOCK_COUNT);
   localparam logic [CNT_W-1:0] LOSS_N = CNT_W'(LOSS_COUNT);

   // Input stage: ui_in[4:0] is captured every edge with no backpressure; a captured
   // sample is consumed on the following edge only when its valid bit (in_q[3]) is 1.
   logic [4:0]       in_q;
   logic [2:0]       smp_value;
   logic             smp_valid;
   logic             smp_clear;

   state_t           state_q, state_d;
   logic [2:0]       exp_q, exp_d;
   logic [CNT_W-1:0] good_q, good_d;
   logic [CNT_W-1:0] bad_q, bad_d;
   logic             err_d, err_q;
   logic             sticky_q;
   logic [7:0]       err_cnt_q;
   logic             oe_q;

   logic [2:0]       samp_next;
   logic             samp_illegal;
   logic [2:0]       exp_next;
   logic             exp_illegal;
   logic             hit;
   logic [CNT_W-1:0] good_inc;
   logic [CNT_W-1:0] bad_inc;

   assign smp_value = in_q[2:0];
   assign smp_valid = in_q[3];
   assign smp_clear = in_q[4];

   mod6_next u_samp_next (
      .value      (smp_value),
      .next_value (samp_next),
      .illegal    (samp_illegal)
   );

   mod6_next u_exp_next (
      .value      (exp_q),
      .next_value (exp_next),
      .illegal    (exp_illegal)
   );

   assign hit      = ~samp_illegal & (smp_value == exp_q);
   assign good_inc = good_q + 1'b1;
   assign bad_inc  = bad_q + 1'b1;

   always_comb begin
      state_d = state_q;
      exp_d   = exp_q;
      good_d  = good_q;
      bad_d   = bad_q;
      err_d   = 1'b0;
      if (smp_valid) begin
         case (state_q)
            ST_HUNT: begin
               if (!samp_illegal) begin
                  exp_d   = samp_next;
                  good_d  = 1'b1;
                  state_d = (LOCK_N == 1'b1) ? ST_LOCKED : ST_VERIFY;
               end
            end
            ST_VERIFY: begin
               if (hit) begin
                  exp_d  = exp_next;
                  good_d = good_inc;
                  if (good_inc >= LOCK_N) begin
                     state_d = ST_LOCKED;
                  end
               end else if (!samp_illegal) begin
                  exp_d  = samp_next;
                  good_d = 1'b1;
               end else begin
                  state_d = ST_HUNT;
                  exp_d   = 3'd0;
                  good_d  = '0;
                  bad_d   = '0;
               end
            end
            ST_LOCKED: begin
               exp_d = exp_next;
               if (!hit) begin
                  err_d = 1'b1;
                  if (LOSS_N == 1'b1) begin
                     state_d = ST_HUNT;
                     exp_d   = 3'd0;
                     good_d  = '0;
                     bad_d   = '0;
                  end else begin
                     state_d = ST_SLIP;
                     bad_d   = 1'b1;
                  end
               end
            end
            ST_SLIP: begin
               exp_d = exp_next;
               if (hit) begin
                  state_d = ST_LOCKED;
                  bad_d   = '0;
               end else begin
                  err_d = 1'b1;
                  bad_d = bad_inc;
                  // Flywheeling failed too often: give up lock and hunt afresh.
                  if (bad_inc >= LOSS_N) begin
                     state_d = ST_HUNT;
                     exp_d   = 3'd0;
                     good_d  = '0;
                     bad_d   = '0;
                  end
               end
            end
            default: begin
               state_d = ST_HUNT;
               exp_d   = 3'd0;
               good_d  = '0;
               bad_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_q    <= '0;
         state_q <= ST_HUNT;
         exp_q   <= 3'd0;
         good_q  <= '0;
         bad_q   <= '0;
         err_q   <= 1'b0;
         oe_q    <= 1'b0;
      end else begin
         in_q    <= ui_in[4:0];
         state_q <= state_d;
         exp_q   <= exp_d;
         good_q  <= good_d;
         bad_q   <= bad_d;
         err_q   <= err_d;
         oe_q    <= 1'b1;
      end
   end

   // Clear takes priority over a coincident error; the error pulse is unaffected.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_q <= 8'd0;
         sticky_q  <= 1'b0;
      end else if (smp_clear) begin
         err_cnt_q <= 8'd0;
         sticky_q  <= 1'b0;
      end else if (err_d) begin
         err_cnt_q <= sat_inc(err_cnt_q);
         sticky_q  <= 1'b1;
      end
   end

   assign uo_out  = {state_q, exp_q, sticky_q, err_q,
                     (state_q == ST_LOCKED) | (state_q == ST_SLIP)};
   assign uio_out = err_cnt_q;
   assign uio_oe  = {8{oe_q}};

   logic unused_inputs;
   assign unused_inputs = &{1'b0, ena, uio_in, ui_in[7:5], exp_illegal};

endmodule

// File: tb/tb_tt_um_mod6_checker.sv
// Randomised scoreboard bench for tt_um_mod6_checker against a sample-level reference model.
module tb_tt_um_mod6_checker;

  localparam int LOCK_COUNT = 3;
  localparam int LOSS_COUNT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_mod6_checker #(.LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [23:0] exp_q[$];

  // reference model: lock mode 0 hunt, 1 verify, 2 locked, 3 slip
  int         m_mode;
  int         m_exp;
  int         m_good;
  int         m_bad;
  int         m_cnt;
  bit         m_sticky;
  logic [4:0] m_in;
  int         seq;

  function automatic int succ(input int x);
    return (x + 1) % 6;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_exp = 0; m_good = 0; m_bad = 0;
    m_cnt = 0; m_sticky = 0; m_in = 5'd0;
  endtask

  task automatic model_hunt();
    m_mode = 0; m_exp = 0; m_good = 0; m_bad = 0;
  endtask

  // Applies the previously captured sample and predicts the outputs after the coming edge.
  task automatic model_step(input logic [4:0] nin);
    int s;
    bit legal, hit, err;
    logic [7:0] uo;
    s = int'(m_in[2:0]);
    legal = (s < 6);
    hit = legal && (s == m_exp);
    err = 0;
    if (m_in[3]) begin
      if (m_mode == 0) begin
        if (legal) begin
          m_exp = succ(s); m_good = 1;
          m_mode = (m_good >= LOCK_COUNT) ? 2 : 1;
        end
      end else if (m_mode == 1) begin
        if (hit) begin
          m_good++; m_exp = succ(m_exp);
          if (m_good >= LOCK_COUNT) m_mode = 2;
        end else if (legal) begin
          m_exp = succ(s); m_good = 1;
        end else begin
          model_hunt();
        end
      end else begin
        m_exp = succ(m_exp);
        if (hit) begin
          m_bad = 0; m_mode = 2;
        end else begin
          err = 1;
          m_bad = (m_mode == 2) ? 1 : m_bad + 1;
          m_mode = 3;
          if (m_bad >= LOSS_COUNT) model_hunt();
        end
      end
    end
    if (m_in[4]) begin
      m_cnt = 0; m_sticky = 0;
    end else if (err) begin
      m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      m_sticky = 1;
    end
    uo = {m_mode[1:0], m_exp[2:0], m_sticky, err, (m_mode >= 2)};
    exp_q.push_back({uo, m_cnt[7:0], 8'hFF});
    m_in = nin;
  endtask

  // monitor: one expected word per edge while stimulus is running
  always @(posedge clk) begin
    logic [23:0] e;
    #2;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({uo_out, uio_out, uio_oe} !== e) begin
        n_fail++;
        $display("FAIL outputs @%0t: uo_out=%h uio_out=%h uio_oe=%h, required uo_out=%h uio_out=%h uio_oe=%h",
                 $time, uo_out, uio_out, uio_oe, e[23:16], e[15:8], e[7:0]);
      end
    end
  end

  // driver tasks
  task automatic drive(input logic [4:0] low);
    @(negedge clk);
    ui_in = {3'($urandom_range(0, 7)), low};
    uio_in = 8'($urandom);
    model_step(low);
  endtask

  task automatic send(input logic [2:0] s, input bit clr = 1'b0);
    drive({clr, 1'b1, s});
  endtask

  task automatic send_good();
    send(3'(seq));
    seq = succ(seq);
  endtask

  task automatic send_bad(input bit clr = 1'b0);
    send(3'((seq + 3) % 6), clr);
    seq = succ(seq);
  endtask

  task automatic idle();
    drive({2'b00, 3'($urandom_range(0, 7))});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_uo_out", 32'(uo_out), 32'h00);
    check("rst_uio_out", 32'(uio_out), 32'h00);
    check("rst_uio_oe", 32'(uio_oe), 32'h00);
    repeat (2) @(negedge clk);
    check("rst_hold_uo_out", 32'(uo_out), 32'h00);
    rst_n = 1'b1;
    ui_in = 8'h00;
    model_reset();
    seq = 0;
    #1;
    check("release_uio_oe", 32'(uio_oe), 32'h00);
    model_step(5'd0);
  endtask

  initial begin
    seq = 0;
    model_reset();
    do_reset();

    // clean stream from reset, with random idle gaps
    for (int i = 0; i < 14; i++) begin
      send_good();
      if ($urandom_range(0, 3) == 0) idle();
    end

    // one 3 replaced by 5 while locked
    while (seq != 3) send_good();
    send(3'd5);
    seq = succ(seq);
    repeat (6) send_good();

    // two consecutive wrong samples drop lock, then relock
    send_bad();
    send_bad();
    repeat (5) send_good();

    // illegal codes while hunting
    do_reset();
    send(3'd7);
    send(3'd6);
    send(3'd7);
    idle();
    repeat (4) send_good();

    // 300 errors while staying in lock, then clear together with an error
    for (int i = 0; i < 300; i++) begin
      send_bad();
      send_good();
    end
    send_bad(1'b1);
    repeat (3) send_good();

    // randomised stream with corruption, illegal codes, gaps and clears
    for (int i = 0; i < 400; i++) begin
      int r;
      bit clr;
      r = $urandom_range(0, 99);
      clr = ($urandom_range(0, 99) < 3);
      if (r < 15) drive({clr, 1'b0, 3'($urandom_range(0, 7))});
      else if (r < 25) send_bad(clr);
      else if (r < 30) begin
        send(3'($urandom_range(6, 7)), clr);
        seq = succ(seq);
      end else send_good();
    end

    // reset while locked with four errors counted
    do_reset();
    repeat (4) send_good();
    for (int i = 0; i < 4; i++) begin
      send_bad();
      send_good();
    end
    repeat (2) send_good();
    do_reset();
    repeat (5) send_good();

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_um_mod6_checker.md
TT_UM_MOD6_CHECKER -- requirements
Module: tt_um_mod6_checker

Interface
REQ-001 SHALL have parameter LOCK_COUNT, default 3: consecutive in-sequence samples needed to declare lock, legal range 1..7.
REQ-002 SHALL have parameter LOSS_COUNT, default 2: consecutive mismatches while locked that drop lock, legal range 1..7.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port ena, input, 1 bit: always high; ignored.
REQ-006 SHALL have port ui_in, input, 8 bits: [2:0] observed count value, [3] sample valid, [4] clear error statistics, [7:5] unused.
REQ-007 SHALL have port uio_in, input, 8 bits: unused.
REQ-008 SHALL have port uo_out, output, 8 bits: [0] locked, [1] error pulse, [2] sticky error, [5:3] expected next value, [7:6] state code.
REQ-009 SHALL have port uio_out, output, 8 bits: error count.
REQ-010 SHALL have port uio_oe, output, 8 bits: 8'hFF once out of reset.

Function
REQ-011 SHALL register ui_in[4:0] in one input stage at each edge; every decision uses the registered copy.
REQ-012 SHALL update all outputs from registers only, so a sample on ui_in at edge N is reflected on the outputs after edge N+1 (2-cycle latency).
REQ-013 SHALL act only on registered samples with valid=1; cycles with valid=0 leave state, counters and expected value unchanged.
REQ-014 SHALL define next(v) = 0 for v=5, else v+1; values 6 and 7 are illegal and never match.
REQ-015 SHALL implement states HUNT=2'b00, VERIFY=2'b01, LOCKED=2'b10, SLIP=2'b11, shown on uo_out[7:6].
REQ-016 HUNT: a legal sample sets expected=next(sample), good=1, and moves to VERIFY (directly to LOCKED if LOCK_COUNT=1); an illegal sample leaves the state in HUNT.
REQ-017 VERIFY, match: set good+1 and expected=next(expected); on reaching LOCK_COUNT, move to LOCKED.
REQ-018 VERIFY, mismatch with a legal sample: reseed expected=next(sample), good=1, stay in VERIFY; with an illegal sample, return to HUNT.
REQ-019 LOCKED, match: set expected=next(expected) and stay; mismatch: flywheel expected=next(expected), set bad=1, signal an error, and move to SLIP (to HUNT if LOSS_COUNT=1).
REQ-020 SLIP, match: clear bad and move to LOCKED; mismatch: flywheel, set bad+1, signal an error, and move to HUNT when bad reaches LOSS_COUNT.
REQ-021 SHALL drive uo_out[0]=1 in LOCKED and SLIP only.
REQ-022 SHALL generate errors only in LOCKED or SLIP; an error SHALL pulse uo_out[1] for exactly one cycle, set sticky uo_out[2], and increment the error count.
REQ-023 SHALL make the error count 8 bits and saturate it at 255 (no wrap).
REQ-024 Registered clear=1 SHALL zero the error count and sticky; if an error occurs in the same cycle, clear wins (count=0, sticky=0) but uo_out[1] still pulses.
REQ-025 Clear SHALL NOT affect state, expected value, good or bad.
REQ-026 SHALL drive uo_out[5:3] with the current expected value: 0 in HUNT, and always within 0..5.

Reset
REQ-027 On rst_n=0, asynchronously: state=HUNT, expected=0, good=0, bad=0, input stage=0, error count=0, sticky=0, uo_out=8'h00, uio_out=8'h00, uio_oe=8'h00.
REQ-028 SHALL set uio_oe to 8'hFF on the first clock edge after rst_n rises.
REQ-029 Reset asserted mid-sequence SHALL abandon lock with no error pulse; after release, lock SHALL be reacquired per REQ-016..017.

Structure
REQ-030 Package tt_mod6_pkg SHALL hold the state encodings, MOD=6, and the ERR_MAX=255 constant.
REQ-031 Sub-module mod6_next (combinational, 3-bit in/out, plus an illegal flag) SHALL compute next() and illegal-value detection; it SHALL be instantiated for both the sample path and the expected-value path.

Verification
REQ-032 Valid stream 0,1,2,3,4,5,0… from reset: uo_out[0] rises 2 cycles after the 3rd sample; error count stays 0.
REQ-033 Locked on 0..5, then one sample 3 is replaced by 5: one uo_out[1] pulse, count=1, sticky=1, SLIP for one sample, then LOCKED again.
REQ-034 Locked, then two consecutive wrong samples: count=2, state HUNT, uo_out[0]=0; relock after 3 correct samples.
REQ-035 Samples 7,6,7 in HUNT: state stays HUNT, no error pulse, count=0.
REQ-036 300 forced errors in lock (alternating valid sequences with relock): count saturates at 255; clear asserted together with an error gives count=0, sticky=0, and a pulse still seen.
REQ-037 rst_n dropped while LOCKED with count=4: all outputs 0 immediately; uio_oe=8'hFF one edge after release.
